// File: rtl/dma_cmd_tx_if.sv
// dma_cmd_tx_if: bundles the request channel, data channel and pin-side
// outputs of the uio command transmitter.
//   req_*   : burst request (kind, base address, length-1) with valid/ready
//   data_*  : data word stream with valid/ready
//   uio_out : {opcode[2:0], 1'b0, addr[3:0]} toward the chip
//   ui_out  : data word paired with uio_out
//   busy    : transmitter not idle
//   done    : pulse on the last command beat of a burst or start
// Modports: slave for the transmitter, master for whatever drives it.
interface dma_cmd_tx_if #(
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [3:0]        req_addr;
  logic [3:0]        req_len;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  logic [7:0]        uio_out;
  logic [DATA_W-1:0] ui_out;
  logic              busy;
  logic              done;

  modport slave (
    input  req_valid, req_kind, req_addr, req_len,
    input  data_valid, data_in,
    output req_ready, data_ready,
    output uio_out, ui_out, busy, done
  );

  modport master (
    output req_valid, req_kind, req_addr, req_len,
    output data_valid, data_in,
    input  req_ready, data_ready,
    input  uio_out, ui_out, busy, done
  );
endinterface

// File: rtl/dma_cmd_tx.sv
// dma_cmd_tx: host-side transmitter for the 8-bit uio command protocol.
// Accepts a burst request (weights / inputs / instructions / start) and,
// for data bursts, emits one registered command+data beat per accepted
// word with an auto-incrementing 4-bit address. Every burst or start is
// followed by GAP_CYCLES idle (opcode 000) cycles before a new request
// can be taken.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : dma_cmd_tx_if.slave (request, data, uio_out/ui_out, busy, done)
module dma_cmd_tx #(
  parameter int GAP_CYCLES = 1,
  parameter int DATA_W     = 8
) (
  input logic         clk,
  input logic         reset,
  dma_cmd_tx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_START,
    S_GAP
  } state_t;

  // GAP also spans the cycle in which the final beat is on the pins, so the
  // counter runs 0..GAP_CYCLES and the pins see GAP_CYCLES zero cycles.
  localparam logic [3:0] GapLast = 4'(GAP_CYCLES);

  state_t            state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic [3:0]        addr_q, addr_d;
  logic [3:0]        count_q, count_d;
  logic [3:0]        gap_q, gap_d;
  logic [7:0]        uio_q, uio_d;
  logic [DATA_W-1:0] ui_q, ui_d;
  logic              done_q, done_d;
  logic [2:0]        opcode;

  // kind 0..3 maps to opcodes 001..100
  assign opcode = {1'b0, kind_q} + 3'd1;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    count_d = count_q;
    gap_d   = gap_q;
    uio_d   = 8'h00;
    ui_d    = ui_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          kind_d  = bus.req_kind;
          addr_d  = bus.req_addr;
          count_d = bus.req_len;
          gap_d   = 4'd0;
          state_d = (bus.req_kind == 2'd3) ? S_START : S_XFER;
        end
      end

      S_XFER: begin
        if (bus.data_valid) begin
          uio_d   = {opcode, 1'b0, addr_q};
          ui_d    = bus.data_in;
          addr_d  = addr_q + 4'd1;
          count_d = count_q - 4'd1;
          if (count_q == 4'd0) begin
            done_d  = 1'b1;
            gap_d   = 4'd0;
            state_d = S_GAP;
          end
        end
      end

      S_START: begin
        uio_d   = {3'b100, 1'b0, addr_q};
        ui_d    = '0;
        done_d  = 1'b1;
        gap_d   = 4'd0;
        state_d = S_GAP;
      end

      S_GAP: begin
        if (gap_q == GapLast) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= 2'd0;
      addr_q  <= 4'd0;
      count_q <= 4'd0;
      gap_q   <= 4'd0;
      uio_q   <= 8'h00;
      ui_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      uio_q   <= uio_d;
      ui_q    <= ui_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.data_ready = (state_q == S_XFER);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.uio_out    = uio_q;
  assign bus.ui_out     = ui_q;
  assign bus.done       = done_q;

endmodule

// File: doc/dma_cmd_tx.md
Name: dma_cmd_tx

Overview:
- Host-side transmitter for the TPU's 8-bit uio command protocol.
- Opcode field is uio[7:5]: 001 fetch weights, 010 fetch inputs, 011 fetch instructions, 100 start, 000 idle. uio[4] is unused and always 0. uio[3:0] is the word address.
- Takes a burst request (kind, base address, length) plus a stream of data words. Emits one command+data beat per accepted word on uio_out/ui_out, with auto-incrementing address and idle gaps.
- Sits in the FPGA/test harness that drives the chip pins.

Parameters:
- GAP_CYCLES, 1, idle cycles (opcode 000) inserted after every burst or start command; legal range 1..15.
- DATA_W, 8, width of the data word driven on ui_out.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  burst request valid
- req_ready  output  1  request can be accepted (high only in IDLE)
- req_kind  input  2  0 weights, 1 inputs, 2 instructions, 3 start
- req_addr  input  4  base word address
- req_len  input  4  burst length minus 1 (1..16 words); ignored for start
- data_valid  input  1  data word valid
- data_ready  output  1  data word can be accepted (high only in XFER)
- data_in  input  DATA_W  data word
- uio_out  output  8  {opcode[2:0], 1'b0, addr[3:0]} toward the chip
- ui_out  output  DATA_W  data word paired with uio_out
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse, coincident with the last command of a burst or the start command on uio_out

Behaviour:
- Reset, synchronous and active-high, takes priority over everything:
  - state returns to IDLE; counters are cleared.
  - uio_out=0, ui_out=0, done=0, busy=0, data_ready=0, req_ready=1.
  - Reset mid-burst discards remaining words; no done is emitted.
- uio_out, ui_out and done are registered. req_ready, data_ready and busy are decoded from the state register.
- Opcode map: kind 0->001, 1->010, 2->011, 3->100.
- IDLE:
  - req_ready=1, uio_out=0.
  - On req_valid&&req_ready: latch kind, addr, count=req_len.
  - Go to START if kind==3, else to XFER.
- XFER:
  - data_ready=1.
  - Each cycle with data_valid: next cycle uio_out={op,0,addr_cur}, ui_out=data_in. Then addr_cur<=addr_cur+1 mod 16 (15 wraps to 0) and count decrements.
  - Cycle without data_valid: next cycle uio_out=0 and ui_out holds its last value. Address and count are unchanged; bubbles are allowed anywhere in a burst.
  - Handshake of the word with count==0: that beat is driven with done=1, and the state goes to GAP.
  - Latency: data handshake at edge N, pins valid during cycle N+1.
- START:
  - Occupies one cycle.
  - Next cycle uio_out={100,0,req_addr}, ui_out=0, done=1.
  - No data is consumed; data_ready stays 0. Then GAP.
- GAP:
  - uio_out=0 for exactly GAP_CYCLES cycles, counted from the cycle after the final command beat. Then IDLE.
  - req_ready=0 throughout, so back-to-back bursts are always separated by at least GAP_CYCLES+1 idle pin cycles (gap plus the IDLE accept cycle).
- Command stream invariants:
  - Never two different opcodes in adjacent cycles without an intervening 000.
  - uio[4] is always 0.
  - A 16-word burst with base address b covers addresses b..b+15 mod 16, each exactly once.
- done never asserts outside the beat carrying the last command.
- busy=1 from the cycle after request accept through the last GAP cycle.

Test Plan:
- Reset then idle: reset for 2 cycles -> uio_out=0x00, ui_out=0, req_ready=1, busy=0, done=0.
- Weights burst, kind=0, addr=2, len=3, data A0..A3 streamed continuously:
  - uio_out=0x22,0x23,0x24,0x25 on consecutive cycles, ui_out=A0..A3.
  - done with 0x25; then GAP_CYCLES cycles of 0x00, then req_ready=1.
- Wrap and bubbles, kind=2, addr=14, len=3, data_valid dropped for 2 cycles after the first word:
  - uio_out=0x6E, 0x00, 0x00, 0x6F, 0x60, 0x61.
  - done on 0x61; exactly 4 data handshakes.
- Start command, kind=3, addr=5 -> one cycle uio_out=0x85 with done=1, data_ready never high, then 0x00 for GAP_CYCLES cycles.
- Full 16-word inputs burst, kind=1, addr=0, len=15 -> uio_out 0x40..0x4F, done on 0x4F. req_valid held high from the start is accepted only after the gap.
- Reset mid-burst, after 2 of 8 words -> next cycle uio_out=0, no done pulse, req_ready=1. A fresh request then starts at its own base address.
